sargantana_tag_set_memory: RTL and testbench
============================================

Name: sargantana_tag_set_memory

Overview:
- Set-associative successor to the single-way tag memory: stores tag and valid bit for WAYS ways per set.
- Per-way hit compare against a lookup tag; masked multi-way write.
- Valid bits live in an addressable array, not per-entry flops, so flush and reset use a multi-cycle sweep FSM.
- Sits in the icache memory wrapper between the icache controller and the data ways.

Parameters:
- WAYS, 4, number of ways; ≥1.
- TAG_DEPTH, 64, number of sets; power of two, ≥2.
- TAG_ADDR_WIDHT, $clog2(TAG_DEPTH), set index width.
- TAG_WIDHT, 20, tag width in bits.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- req_i  in  1  access request.
- we_i  in  1  1 = write, 0 = read/lookup.
- way_mask_i  in  WAYS  ways written on write; ignored on read.
- vbit_i  in  1  valid bit written to masked ways.
- flush_i  in  1  invalidate all sets.
- addr_i  in  TAG_ADDR_WIDHT  set index.
- data_i  in  TAG_WIDHT  tag written to masked ways.
- cmp_tag_i  in  TAG_WIDHT  lookup tag, sampled with a read.
- ready_o  out  1  block can accept a request.
- rvalid_o  out  1  one-cycle pulse: read results valid.
- data_o  out  WAYS*TAG_WIDHT  way w tag at bits [w*TAG_WIDHT +: TAG_WIDHT].
- vbit_o  out  WAYS  per-way valid bits of last read.
- hit_o  out  WAYS  per-way hit of last read.
- hit_any_o  out  1  OR of hit_o.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rstn_i is asynchronous, active-low.
- Reset values:
  - FSM = SWEEP, sweep counter = 0, ready_o = 0, rvalid_o = 0.
  - data_o = 0, vbit_o = 0, hit_o = 0, hit_any_o = 0, registered cmp tag = 0.
  - Tag array contents are not reset.
- FSM states IDLE and SWEEP:
  - SWEEP: each cycle, clear the valid bits of all ways at set = counter, then counter += 1.
  - When counter == TAG_DEPTH-1 is cleared, go to IDLE and wrap counter to 0.
  - A sweep lasts exactly TAG_DEPTH cycles.
  - IDLE -> SWEEP when flush_i = 1. Counter restarts at 0. vbit_o, hit_o and hit_any_o clear on the entry edge.
  - flush_i during SWEEP is ignored. The sweep in progress continues; no restart and no extension.
- ready_o = (state == IDLE) & !flush_i, combinational.
- Accept condition: req_i & ready_o. Requests while ready_o = 0 are dropped, not queued. The requester must hold req_i until accepted.
- Write accepted at edge t:
  - For each w with way_mask_i[w] = 1: tag[addr_i][w] <= data_i, valid[addr_i][w] <= vbit_i.
  - Unmasked ways are unchanged.
  - way_mask_i = 0 is a legal no-op.
  - Read outputs are unchanged; no rvalid_o pulse.
- Read accepted at edge t:
  - At t+1, data_o and vbit_o hold all ways of addr_i.
  - cmp_tag_i is registered at t.
  - rvalid_o = 1 for exactly the cycle after t.
- hit_o[w] = vbit_o[w] & (data_o way w == registered cmp tag), combinational from registered values. hit_any_o = |hit_o.
- data_o, vbit_o and hit_o hold their values until the next accepted read, a flush entry, or reset.
- Back-to-back operations: one accepted request per cycle, fully pipelined.
  - A read at t+1 of a set written at t returns the new contents.
  - More than one masked way may hit; no one-hot guarantee. The controller must never create duplicates.
- Reset mid-sweep or mid-read: everything returns to reset values immediately, and a fresh full sweep starts after rstn_i deasserts.

Test Plan:
- Reset, TAG_DEPTH = 64 -> ready_o = 0 for 64 cycles after rstn_i rises, then 1. A read of any set then gives vbit_o = 4'b0000 and hit_any_o = 0.
- Write set 5, mask 4'b0100, tag 0xABCDE, vbit 1; next cycle read set 5 with cmp 0xABCDE -> rvalid_o pulses 1 cycle; way 2 of data_o = 0xABCDE; vbit_o = 4'b0100; hit_o = 4'b0100; hit_any_o = 1.
- Same setup, read with cmp 0xABCDF -> hit_o = 0, vbit_o = 4'b0100.
- Write set 5 ways 0 and 3 with tag 0x11111 (mask 4'b1001), then flush_i for 1 cycle:
  - ready_o = 0 for 64 cycles; vbit_o clears at flush entry.
  - flush_i pulsed again at sweep cycle 30 does not lengthen the sweep.
  - A read of set 5 afterwards gives vbit_o = 0.
- req_i held high during a sweep, and req_i with flush_i in the same IDLE cycle -> the request is not accepted; no rvalid_o; array unchanged.
- rstn_i asserted at sweep cycle 20 and during a read's output cycle -> outputs go to 0 asynchronously; a fresh 64-cycle sweep follows deassertion.

Source files
------------

// File: rtl/sargantana_tag_set_memory.sv
// Set-associative icache tag memory: WAYS tag/valid entries per set, per-way hit compare,
// masked multi-way write and a sweep FSM that clears every set's valid bits on reset or flush.
module sargantana_tag_set_memory #(
   parameter int unsigned WAYS           = 4,
   parameter int unsigned TAG_DEPTH      = 64,
   parameter int unsigned TAG_ADDR_WIDHT = $clog2(TAG_DEPTH),
   parameter int unsigned TAG_WIDHT      = 20
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      req_i,
   input  logic                      we_i,
   input  logic [WAYS-1:0]           way_mask_i,
   input  logic                      vbit_i,
   input  logic                      flush_i,
   input  logic [TAG_ADDR_WIDHT-1:0] addr_i,
   input  logic [TAG_WIDHT-1:0]      data_i,
   input  logic [TAG_WIDHT-1:0]      cmp_tag_i,
   output logic                      ready_o,
   output logic                      rvalid_o,
   output logic [WAYS*TAG_WIDHT-1:0] data_o,
   output logic [WAYS-1:0]           vbit_o,
   output logic [WAYS-1:0]           hit_o,
   output logic                      hit_any_o
);

   typedef enum logic [0:0] {StIdle, StSweep} state_e;

   state_e                          state_q;
   logic [TAG_ADDR_WIDHT-1:0]       cnt_q;

   logic [TAG_WIDHT-1:0]            tag_mem   [TAG_DEPTH][WAYS];
   logic [WAYS-1:0]                 valid_mem [TAG_DEPTH];

   logic [WAYS-1:0][TAG_WIDHT-1:0]  rdata_q;
   logic [WAYS-1:0]                 rvbit_q;
   logic [TAG_WIDHT-1:0]            cmp_q;
   logic                            rvalid_q;
   logic [WAYS-1:0]                 hit;

   logic accept;
   logic wr_en;
   logic rd_en;
   logic flush_start;
   logic sweep_last;

   assign ready_o     = (state_q == StIdle) & ~flush_i;
   assign accept      = req_i & ready_o;
   assign wr_en       = accept & we_i;
   assign rd_en       = accept & ~we_i;
   assign flush_start = (state_q == StIdle) & flush_i;
   assign sweep_last  = (cnt_q == TAG_ADDR_WIDHT'(TAG_DEPTH - 1));

   // Sweep FSM; flush_i while sweeping is ignored so a sweep is always exactly TAG_DEPTH cycles.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= StSweep;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            StSweep: begin
               if (sweep_last) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StIdle: begin
               if (flush_i) begin
                  state_q <= StSweep;
                  cnt_q   <= '0;
               end
            end
            default: begin
               state_q <= StSweep;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Tag array is deliberately left unreset; only the valid bits carry meaning after a sweep.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int w = 0; w < int'(WAYS); w++) begin
            if (way_mask_i[w]) begin
               tag_mem[addr_i][w] <= data_i;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (state_q == StSweep) begin
         valid_mem[cnt_q] <= '0;
      end else if (wr_en) begin
         for (int w = 0; w < int'(WAYS); w++) begin
            if (way_mask_i[w]) begin
               valid_mem[addr_i][w] <= vbit_i;
            end
         end
      end
   end

   // Read result registers hold until the next accepted read; flush entry drops the valid view.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rdata_q  <= '0;
         rvbit_q  <= '0;
         cmp_q    <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= rd_en;
         if (rd_en) begin
            for (int w = 0; w < int'(WAYS); w++) begin
               rdata_q[w] <= tag_mem[addr_i][w];
            end
            rvbit_q <= valid_mem[addr_i];
            cmp_q   <= cmp_tag_i;
         end else if (flush_start) begin
            rvbit_q <= '0;
         end
      end
   end

   always_comb begin
      hit = '0;
      for (int w = 0; w < int'(WAYS); w++) begin
         hit[w] = rvbit_q[w] & (rdata_q[w] == cmp_q);
      end
   end

   assign data_o    = rdata_q;
   assign vbit_o    = rvbit_q;
   assign rvalid_o  = rvalid_q;
   assign hit_o     = hit;
   assign hit_any_o = |hit;

endmodule

// File: tb/tb_sargantana_tag_set_memory.sv
// Scoreboard bench for sargantana_tag_set_memory: a tag/valid model predicts each read, the
// monitor pops the prediction on every rvalid_o pulse; sweeps, flushes and resets are timed.
module tb_sargantana_tag_set_memory;

   localparam int unsigned WAYS  = 4;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned AW    = 6;
   localparam int unsigned TW    = 20;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic                 req;
   logic                 we;
   logic [WAYS-1:0]      way_mask;
   logic                 vbit;
   logic                 flush;
   logic [AW-1:0]        addr;
   logic [TW-1:0]        data;
   logic [TW-1:0]        cmp;
   logic                 ready_o;
   logic                 rvalid_o;
   logic [WAYS*TW-1:0]   data_o;
   logic [WAYS-1:0]      vbit_o;
   logic [WAYS-1:0]      hit_o;
   logic                 hit_any_o;

   always #5 clk = ~clk;

   sargantana_tag_set_memory #(
      .WAYS           (WAYS),
      .TAG_DEPTH      (DEPTH),
      .TAG_ADDR_WIDHT (AW),
      .TAG_WIDHT      (TW)
   ) dut (
      .clk_i      (clk),
      .rstn_i     (rstn),
      .req_i      (req),
      .we_i       (we),
      .way_mask_i (way_mask),
      .vbit_i     (vbit),
      .flush_i    (flush),
      .addr_i     (addr),
      .data_i     (data),
      .cmp_tag_i  (cmp),
      .ready_o    (ready_o),
      .rvalid_o   (rvalid_o),
      .data_o     (data_o),
      .vbit_o     (vbit_o),
      .hit_o      (hit_o),
      .hit_any_o  (hit_any_o)
   );

   typedef struct {
      logic [WAYS*TW-1:0] data;
      logic [WAYS*TW-1:0] dmask;
      logic [WAYS-1:0]    vbit;
      logic [WAYS-1:0]    hit;
   } exp_t;

   exp_t             exp_q[$];
   logic [TW-1:0]    m_tag   [DEPTH][WAYS];
   logic [WAYS-1:0]  m_valid [DEPTH];
   logic [WAYS-1:0]  m_known [DEPTH];
   int               n_vec  = 0;
   int               n_miss = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rstn && rvalid_o) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_rvalid", 128'(rvalid_o), 128'(1'b0));
         end else begin
            e = exp_q.pop_front();
            check_eq("rd_data", 128'(data_o & e.dmask), 128'(e.data));
            check_eq("rd_vbit", 128'(vbit_o), 128'(e.vbit));
            check_eq("rd_hit", 128'(hit_o), 128'(e.hit));
            check_eq("rd_hit_any", 128'(hit_any_o), 128'(|e.hit));
         end
      end
   end

   task automatic clear_model_valid();
      for (int s = 0; s < int'(DEPTH); s++) m_valid[s] = '0;
   endtask

   // Called just after a posedge; returns just after the posedge that accepted the request.
   task automatic do_op(input logic w, input logic [WAYS-1:0] mask, input logic vb,
                        input logic [AW-1:0] a, input logic [TW-1:0] d, input logic [TW-1:0] c);
      int   n = 0;
      exp_t e;
      we = w; way_mask = mask; vbit = vb; addr = a; data = d; cmp = c; req = 1'b1;
      @(negedge clk);
      while (!ready_o && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!ready_o) begin
         check_eq("accept_timeout", 128'(ready_o), 128'(1'b1));
      end else if (w) begin
         for (int i = 0; i < int'(WAYS); i++) begin
            if (mask[i]) begin
               m_tag[a][i]   = d;
               m_valid[a][i] = vb;
               m_known[a][i] = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < int'(WAYS); i++) begin
            e.data[i*TW +: TW]  = m_known[a][i] ? m_tag[a][i] : '0;
            e.dmask[i*TW +: TW] = m_known[a][i] ? '1 : '0;
            e.vbit[i]           = m_valid[a][i];
            e.hit[i]            = m_valid[a][i] && m_known[a][i] && (m_tag[a][i] == c);
         end
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      req = 1'b0;
   endtask

   task automatic read_pulse_check();
      @(negedge clk);
      check_eq("rvalid_high", 128'(rvalid_o), 128'(1'b1));
      @(negedge clk);
      check_eq("rvalid_low", 128'(rvalid_o), 128'(1'b0));
      @(posedge clk);
      #1;
   endtask

   // Counts sweep cycles (ready_o low); optionally pulses flush or holds req mid-sweep.
   task automatic count_sweep(input int pulse_at, input int req_from, input int req_to);
      int n = 0;
      @(negedge clk);
      while (!ready_o && n < 300) begin
         n++;
         flush = (n == pulse_at);
         if (n == req_from) req = 1'b1;
         if (n == req_to) req = 1'b0;
         @(negedge clk);
      end
      flush = 1'b0;
      req   = 1'b0;
      check_eq("sweep_len", 128'(n), 128'(DEPTH));
      @(posedge clk);
      #1;
   endtask

   task automatic start_flush(input logic with_req);
      flush = 1'b1;
      if (with_req) begin
         we = 1'b0; addr = 7; req = 1'b1;
      end
      #1;
      check_eq("ready_during_flush", 128'(ready_o), 128'(1'b0));
      @(posedge clk);
      #1;
      flush = 1'b0;
      req   = 1'b0;
      check_eq("flush_vbit_clr", 128'(vbit_o), 128'(0));
      check_eq("flush_hit_any_clr", 128'(hit_any_o), 128'(1'b0));
      clear_model_valid();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_ready"}, 128'(ready_o), 128'(1'b0));
      check_eq({tag, "_rvalid"}, 128'(rvalid_o), 128'(1'b0));
      check_eq({tag, "_data"}, 128'(data_o), 128'(0));
      check_eq({tag, "_vbit"}, 128'(vbit_o), 128'(0));
      check_eq({tag, "_hit_any"}, 128'(hit_any_o), 128'(1'b0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
      $fatal(1);
   end

   initial begin
      rstn = 1'b0; req = 1'b0; we = 1'b0; way_mask = '0; vbit = 1'b0; flush = 1'b0;
      addr = '0; data = '0; cmp = '0;
      for (int s = 0; s < int'(DEPTH); s++) begin
         m_valid[s] = '0;
         m_known[s] = '0;
      end

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rstn = 1'b1;
      count_sweep(0, 0, 0);

      do_op(1'b0, 4'b0000, 1'b0, 6'd9, 20'h0, 20'h0);
      read_pulse_check();

      do_op(1'b1, 4'b0100, 1'b1, 6'd5, 20'hABCDE, 20'h0);
      do_op(1'b0, 4'b0000, 1'b0, 6'd5, 20'h0, 20'hABCDE);
      read_pulse_check();
      do_op(1'b0, 4'b0000, 1'b0, 6'd5, 20'h0, 20'hABCDF);
      do_op(1'b1, 4'b1001, 1'b1, 6'd5, 20'h11111, 20'h0);
      do_op(1'b0, 4'b0000, 1'b0, 6'd5, 20'h0, 20'h11111);
      do_op(1'b1, 4'b0000, 1'b1, 6'd5, 20'h77777, 20'h0);
      do_op(1'b0, 4'b0000, 1'b0, 6'd5, 20'h0, 20'hABCDE);
      do_op(1'b1, 4'b0011, 1'b1, 6'd7, 20'h2468A, 20'h0);
      do_op(1'b0, 4'b0000, 1'b0, 6'd7, 20'h0, 20'h2468A);

      for (int k = 0; k < 24; k++) begin
         do_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               6'($urandom_range(16, 23)), 20'h10000 + 20'($urandom_range(0, 3)),
               20'h10000 + 20'($urandom_range(0, 3)));
      end

      // Flush with a stray flush pulse mid-sweep; vbit_o is non-zero going in.
      do_op(1'b0, 4'b0000, 1'b0, 6'd5, 20'h0, 20'h11111);
      repeat (2) @(posedge clk);
      #1;
      start_flush(1'b0);
      count_sweep(30, 0, 0);
      do_op(1'b0, 4'b0000, 1'b0, 6'd5, 20'h0, 20'h11111);
      read_pulse_check();

      // Write request held during a sweep must be dropped.
      do_op(1'b1, 4'b0010, 1'b1, 6'd5, 20'h33333, 20'h0);
      we = 1'b1; way_mask = 4'b1111; vbit = 1'b1; addr = 6'd5; data = 20'h55555;
      start_flush(1'b0);
      count_sweep(0, 10, 50);
      do_op(1'b0, 4'b0000, 1'b0, 6'd5, 20'h0, 20'h55555);

      // Request in the same cycle as flush must be dropped.
      do_op(1'b1, 4'b0011, 1'b1, 6'd7, 20'h2468A, 20'h0);
      start_flush(1'b1);
      count_sweep(0, 0, 0);
      do_op(1'b0, 4'b0000, 1'b0, 6'd7, 20'h0, 20'h2468A);
      repeat (2) @(posedge clk);
      #1;

      // Reset at sweep cycle 20.
      start_flush(1'b0);
      repeat (20) @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check_reset_outputs("rst_sweep");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      clear_model_valid();
      count_sweep(0, 0, 0);

      // Reset during a read's output cycle.
      do_op(1'b1, 4'b1111, 1'b1, 6'd3, 20'h0F0F0, 20'h0);
      do_op(1'b0, 4'b0000, 1'b0, 6'd3, 20'h0, 20'h0F0F0);
      @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check_reset_outputs("rst_read");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      clear_model_valid();
      count_sweep(0, 0, 0);
      do_op(1'b0, 4'b0000, 1'b0, 6'd3, 20'h0, 20'h0F0F0);
      read_pulse_check();

      repeat (3) @(posedge clk);
      #1;
      check_eq("scoreboard_drain", 128'(exp_q.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
